// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands and opcode in,
// result plus status flags out, each side with its own valid/ready pair.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, opcode, out_ready,
        input  in_ready, out_valid, out_result, carry, overflow, zero, err, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, opcode, out_ready,
        output in_ready, out_valid, out_result, carry, overflow, zero, err, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: logic/add/sub/compare in one cycle, shift-add multiply and
// bit-serial shifts iterated in EXEC; results held in DONE until consumed.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } res_t;

    function automatic res_t alu1(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
        logic        [WIDTH:0]   s;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        res_t                    o;
        o  = '0;
        s  = '0;
        sa = a;
        sb = b;
        case (op)
            4'h0: begin
                s   = {1'b0, a} + {1'b0, b};
                o.r = s[WIDTH-1:0];
                o.c = s[WIDTH];
                o.v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            4'h1: begin
                // carry-out of A + ~B + 1 is the inverse of borrow
                s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                o.r = s[WIDTH-1:0];
                o.c = ~s[WIDTH];
                o.v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            4'h2:    o.r = ~a;
            4'h3:    o.r = a & b;
            4'h4:    o.r = a | b;
            4'h5:    o.r = a ^ b;
            4'h6:    o.r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            4'h7:    o.r = {{(WIDTH-1){1'b0}}, (a == b)};
            default: o   = '0;
        endcase
        return o;
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                    input logic [WIDTH-1:0] lo,
                                                    input logic [WIDTH-1:0] a);
        logic [WIDTH:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
        return {sum, lo[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op,
                                                input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        case (op)
            4'h9:    return {x[WIDTH-2:0], 1'b0};
            4'hA:    return {1'b0, x[WIDTH-1:1]};
            default: return xs >>> 1;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, lo_q, lo_d, hi_q, hi_d, res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rdy_q, vld_q, busy_q, c_q, c_d, v_q, v_d, z_q, z_d, e_q, e_d;
    logic [2*WIDTH-1:0] prod;
    logic [SW-1:0]    n;
    res_t             one;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        c_d     = c_q;
        v_d     = v_q;
        e_d     = e_q;
        prod    = '0;
        one     = '0;
        n       = bus.in_b[SW-1:0];
        case (state_q)
            IDLE: if (rdy_q && bus.in_valid) begin
                a_d  = bus.in_a;
                op_d = bus.opcode;
                hi_d = '0;
                if (bus.opcode == 4'h8) begin
                    lo_d    = bus.in_b;
                    cnt_d   = CNT_MUL;
                    state_d = EXEC;
                end else if (bus.opcode inside {4'h9, 4'hA, 4'hB}) begin
                    lo_d  = bus.in_a;
                    cnt_d = {1'b0, n};
                    if (n == '0) begin
                        state_d = DONE;
                        res_d   = bus.in_a;
                        c_d     = 1'b0;
                        v_d     = 1'b0;
                        e_d     = 1'b0;
                    end else begin
                        state_d = EXEC;
                    end
                end else begin
                    one     = alu1(bus.opcode, bus.in_a, bus.in_b);
                    res_d   = one.r;
                    c_d     = one.c;
                    v_d     = one.v;
                    e_d     = bus.opcode[3];
                    state_d = DONE;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == 4'h8) begin
                    prod = mul_step(hi_q, lo_q, a_q);
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    lo_d = shift1(op_q, lo_q);
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    res_d   = lo_d;
                    c_d     = (op_q == 4'h8) && (|prod[2*WIDTH-1:WIDTH]);
                    v_d     = (op_q == 4'h8) && (|prod[2*WIDTH-1:WIDTH]);
                    e_d     = 1'b0;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        z_d = (res_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == IDLE);
            vld_q   <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
            res_q   <= res_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            e_q     <= e_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q  <= a_d;
        lo_q <= lo_d;
        hi_q <= hi_d;
    end

    assign bus.in_ready   = rdy_q;
    assign bus.out_valid  = vld_q;
    assign bus.busy       = busy_q;
    assign bus.out_result = res_q;
    assign bus.carry      = c_q;
    assign bus.overflow   = v_q;
    assign bus.zero       = z_q;
    assign bus.err        = e_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic model of results, flags and latency.
module tb_alu_seq;
    localparam int W = 4;

    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic c, output logic v, output logic e,
                                  output int lat);
        longint ua, ub, sa, sb, t, mask, smax, smin, full;
        int     n;
        full = longint'(1) <<< W;
        mask = full - 1;
        smax = (full >>> 1) - 1;
        smin = -(full >>> 1);
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = a[W-1] ? ua - full : ua;
        sb   = b[W-1] ? ub - full : ub;
        n    = int'(ub % W);
        t = 0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
        case (op)
            4'h0: begin t = ua + ub; c = (t > mask); v = (sa + sb > smax) || (sa + sb < smin); end
            4'h1: begin t = ua - ub; c = (ua < ub); v = (sa - sb > smax) || (sa - sb < smin); end
            4'h2: t = ~ua;
            4'h3: t = ua & ub;
            4'h4: t = ua | ub;
            4'h5: t = ua ^ ub;
            4'h6: t = (sa < sb) ? 1 : 0;
            4'h7: t = (ua == ub) ? 1 : 0;
            4'h8: begin t = ua * ub; c = ((t >> W) != 0); v = c; lat = W + 1; end
            4'h9: begin t = ua << n; lat = (n == 0) ? 1 : n + 1; end
            4'hA: begin t = ua >> n; lat = (n == 0) ? 1 : n + 1; end
            4'hB: begin t = sa >>> n; lat = (n == 0) ? 1 : n + 1; end
            default: begin t = 0; e = 1'b1; end
        endcase
        t = t & mask;
        r = t[W-1:0];
    endfunction

    // model state: one outstanding request, when its result is due, when idle resumes
    logic       m_pend = 1'b0;
    longint     m_due = 0;
    longint     m_free = 0;
    logic [W-1:0] m_r;
    logic       m_c, m_v, m_e;
    int         m_lat;
    logic       exp_ready, exp_valid;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_out_valid", bus.out_valid, 1'b0);
            chk1("rst_in_ready", bus.in_ready, 1'b0);
            chk1("rst_busy", bus.busy, 1'b0);
            chkw("rst_result", bus.out_result, '0);
            chk1("rst_carry", bus.carry, 1'b0);
            chk1("rst_overflow", bus.overflow, 1'b0);
            chk1("rst_zero", bus.zero, 1'b0);
            chk1("rst_err", bus.err, 1'b0);
            m_pend = 1'b0;
            m_free = cyc + 2;
        end else begin
            exp_ready = !m_pend && (cyc >= m_free);
            exp_valid = m_pend && (cyc >= m_due);
            chk1("in_ready", bus.in_ready, exp_ready);
            chk1("busy", bus.busy, m_pend);
            chk1("out_valid", bus.out_valid, exp_valid);
            if (exp_valid && bus.out_valid) begin
                chkw("result", bus.out_result, m_r);
                chk1("carry", bus.carry, m_c);
                chk1("overflow", bus.overflow, m_v);
                chk1("zero", bus.zero, m_r == '0);
                chk1("err", bus.err, m_e);
                if (bus.out_ready) begin
                    m_pend = 1'b0;
                    m_free = cyc + 1;
                end
            end
            if (bus.in_valid && exp_ready) begin
                model(bus.opcode, bus.in_a, bus.in_b, m_r, m_c, m_v, m_e, m_lat);
                m_pend = 1'b1;
                m_due  = cyc + m_lat;
            end
        end
    end

    task automatic txn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, output logic [W-1:0] r, output logic c,
                       output logic v, output logic z, output logic e, output int lat);
        int     t;
        longint acc;
        t = 0;
        while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
        chk1("ready_timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.opcode   = op;
        acc          = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        t = 0;
        while (!bus.out_valid && t < 100) begin @(posedge clk); #1; t++; end
        chk1("valid_timeout", bus.out_valid, 1'b1);
        lat = int'(cyc - acc);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = W'($urandom);
            bus.opcode   = 4'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        r = bus.out_result; c = bus.carry; v = bus.overflow; z = bus.zero; e = bus.err;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [W-1:0] r;
    logic         c, v, z, e;
    int           lat;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.opcode = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk1("ready_after_release", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("ready_first_clock", bus.in_ready, 1'b1);

        txn(4'h0, 4'd7, 4'd1, 0, r, c, v, z, e, lat);
        chki("add_lat", lat, 1); chkw("add_r", r, 4'd8); chk1("add_v", v, 1'b1);
        chk1("add_c", c, 1'b0); chk1("add_z", z, 1'b0);
        txn(4'h1, 4'd3, 4'd3, 0, r, c, v, z, e, lat);
        chkw("sub33_r", r, 4'd0); chk1("sub33_z", z, 1'b1); chk1("sub33_c", c, 1'b0);
        txn(4'h1, 4'd2, 4'd5, 0, r, c, v, z, e, lat);
        chkw("sub25_r", r, 4'd13); chk1("sub25_c", c, 1'b1);
        txn(4'h8, 4'd5, 4'd3, 0, r, c, v, z, e, lat);
        chki("mul_lat", lat, 5); chkw("mul53_r", r, 4'd15); chk1("mul53_c", c, 1'b0);
        txn(4'h8, 4'd15, 4'd15, 0, r, c, v, z, e, lat);
        chkw("mulff_r", r, 4'd1); chk1("mulff_c", c, 1'b1); chk1("mulff_v", v, 1'b1);
        txn(4'hB, 4'b1000, 4'd2, 0, r, c, v, z, e, lat);
        chki("sra_lat", lat, 3); chkw("sra_r", r, 4'b1110);
        txn(4'h9, 4'd9, 4'd0, 0, r, c, v, z, e, lat);
        chki("sll0_lat", lat, 1); chkw("sll0_r", r, 4'd9);
        txn(4'hD, 4'd6, 4'd3, 5, r, c, v, z, e, lat);
        chk1("bad_err", e, 1'b1); chk1("bad_z", z, 1'b1); chkw("bad_r", r, 4'd0);
        txn(4'h0, 4'd9, 4'd9, 5, r, c, v, z, e, lat);
        chkw("hold_r", r, 4'd2); chk1("hold_c", c, 1'b1); chk1("hold_v", v, 1'b1);

        // reset in the second EXEC cycle of a multiply
        bus.in_valid = 1'b1; bus.in_a = 4'd6; bus.in_b = 4'd7; bus.opcode = 4'h8;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk1("mrst_valid", bus.out_valid, 1'b0); chk1("mrst_busy", bus.busy, 1'b0);
        chk1("mrst_ready", bus.in_ready, 1'b0); chkw("mrst_r", bus.out_result, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("mrst_ready_after", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.opcode    = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand/result width; legal values are 4, 8, 16 and 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port in_a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port in_b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port opcode, input, 4 bits: the operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_result, output, WIDTH bits: the result.
REQ-012 The block SHALL have ports carry, overflow, zero, err, outputs, 1 bit each: result flags, valid while out_valid=1.
REQ-013 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, in_valid=1 SHALL register in_a, in_b and opcode; the next state SHALL be DONE for single-cycle opcodes and EXEC for iterative opcodes.
REQ-016 Single-cycle opcodes SHALL be: 0000 add, 0001 sub (A-B), 0010 NOT A, 0011 AND, 0100 OR, 0101 XOR, 0110 signed A<B (result 1/0, zero-extended), 0111 A==B (result 1/0).
REQ-017 Each single-cycle opcode SHALL drive out_valid exactly 1 cycle after acceptance.
REQ-018 add SHALL set carry to the carry-out of bit WIDTH-1, and overflow to 1 when the operand signs are equal and the result sign differs.
REQ-019 sub SHALL compute A + ~B + 1; carry SHALL be 1 when a borrow occurs (A<B unsigned), and overflow SHALL be 1 when the operand signs differ and the result sign differs from A.
REQ-020 For opcodes other than add and sub, carry and overflow SHALL be 0, except where REQ-021 says otherwise.
REQ-021 Opcode 1000 mul SHALL be an unsigned shift-add multiply taking exactly WIDTH EXEC cycles; out_result SHALL be the low WIDTH bits of the product; carry and overflow SHALL both be 1 when the high WIDTH bits are nonzero.
REQ-022 Opcodes 1001 sll, 1010 srl and 1011 sra SHALL shift A by a shift amount n equal to in_b[log2(WIDTH)-1:0], one bit per EXEC cycle, taking n cycles.
REQ-023 A shift with n=0 SHALL skip EXEC, go straight to DONE, and give a latency of 1.
REQ-024 Opcodes 1100-1111 SHALL go straight to DONE with out_result=0 and err=1; err SHALL be 0 for every defined opcode.
REQ-025 zero SHALL be 1 exactly when out_result==0, for all opcodes.
REQ-026 The block SHALL hold DONE, out_result and the flags stable until out_ready=1; the DONE->IDLE transition SHALL happen on the cycle out_valid and out_ready are both 1.
REQ-027 The block SHALL NOT accept a new request in the cycle it leaves DONE; the next acceptance SHALL be no earlier than one cycle later in IDLE.
REQ-028 While in_ready=0, the block SHALL ignore in_valid and changes to the input operands; registered operands SHALL NOT change in EXEC.
REQ-029 Iteration counter width SHALL be log2(WIDTH)+1 bits; the counter SHALL NOT wrap before completion.

Reset
REQ-030 When rst=1, regardless of clk, the block SHALL force state IDLE and clear in_ready... to the values below.
REQ-031 During reset the outputs SHALL be: out_valid=0, out_result=0, carry=0, overflow=0, zero=0, err=0, busy=0, in_ready=0.
REQ-032 On the first clock after rst deasserts, in_ready SHALL be 1.
REQ-033 Reset asserted during EXEC or DONE SHALL discard the operation, with no out_valid pulse afterward.

Verification (WIDTH=4)
REQ-034 add A=7, B=1 -> one cycle later out_valid=1, result=8, overflow=1, carry=0, zero=0.
REQ-035 sub A=3, B=3 -> result=0, zero=1, carry=0; sub A=2, B=5 -> result=13, carry=1.
REQ-036 mul A=5, B=3 -> out_valid 5 cycles after accept (4 EXEC + DONE entry), result=15, carry=0; mul A=15, B=15 -> result=1, carry=1, overflow=1.
REQ-037 sra A=1000b, B=2 -> result=1110b after 2 EXEC cycles; sll with B=0 -> latency 1, result=A.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> result and flags stable; change in_a/in_valid during that time -> no effect; opcode 1101 -> err=1, zero=1.
REQ-039 Assert rst mid-mul (EXEC cycle 2) -> outputs at reset values immediately, in_ready=1 one cycle after release, no stale out_valid.
